lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//   Load/store sequencer between the pipeline MEM stage and the data-memory bus.
//   Accepts one byte/half/word request, issues 1 or 2 word-aligned bus accesses
//   (two when the access straddles a word boundary), then merges read lanes and
//   sign/zero-extends load data.
//   Drives byte enables and lane-shifted write data for stores. Times out hung accesses.
// PARAMETERS
//   MAX_WAIT  255  cycles mem_req may stay unacknowledged before abort (1..255)
// PORTS
//   clk           in   1   clock, rising edge
//   rst_n         in   1   asynchronous reset, active-low
//   req_valid     in   1   pipeline request valid
//   req_ready     out  1   block can accept a request (state IDLE)
//   req_we        in   1   1=store, 0=load
//   req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in   1   1=zero-extend load (lbu/lhu), ignored for word/store
//   req_addr      in   32  byte address
//   req_wdata     in   32  store data, right-aligned
//   rsp_valid     out  1   one-cycle response pulse
//   rsp_rdata     out  32  extended load data (0 for stores and errors)
//   rsp_err       out  1   qualified by rsp_valid: timeout or illegal size
//   busy          out  1   state != IDLE
//   mem_req       out  1   bus request, held until mem_ack
//   mem_we        out  1   bus write
//   mem_addr      out  32  word address, bits[1:0]=0
//   mem_be        out  4   byte enables, bit i = byte lane i (little-endian)
//   mem_wdata     out  32  lane-aligned write data, disabled lanes driven 0
//   mem_ack       in   1   access complete; mem_rdata valid same cycle
//   mem_rdata     in   32  read word
// BEHAVIOUR
//   Reset (async, immediate): state IDLE, all outputs 0 except req_ready=1; in-flight access dropped.
//   States: IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE.
//   IDLE: req_valid&req_ready latches request. size 11 -> RESP with err, no bus access.
//     split = (off + nbytes) > 4, off=addr[1:0], nbytes=1/2/4.
//   ACC0: mem_req=1, addr={addr[31:2],2'b00}, be=(mask<<off)[3:0], wdata=(wdata<<8*off)[31:0].
//     On mem_ack: capture rdata low word; split ? ACC1 : RESP.
//   ACC1: addr = ACC0 addr + 4 (wraps at 2^32), be=(mask<<off)[7:4], wdata=(wdata<<8*off)[63:32].
//     On mem_ack: capture high word; -> RESP.
//   mask = 0x1/0x3/0xF, shifts over 8-byte window; mem_we=req_we during ACC0/ACC1.
//   Wait counter cleared on entering ACC0/ACC1, increments while mem_req&!mem_ack;
//     reaching MAX_WAIT without ack -> drop mem_req, RESP with err=1, rdata=0.
//   RESP: rsp_valid=1 for exactly one cycle; load data = ({hi,lo} >> 8*off) truncated
//     to size, then sign-extended (bit 7/15) unless req_unsigned; word unchanged.
//   Latency: aligned access accepted at cycle 0 -> rsp_valid at cycle ack_cycle+1;
//     zero-wait memory gives 3 cycles (accept, ACC0, RESP); split adds one access.
//   mem_ack while mem_req=0 ignored. Next request accepted only after RESP (no overlap).
//   rsp_rdata/rsp_err hold last value after pulse until next RESP.
// STRUCTURE
//   Shared package lsu_pkg: size codes (SZ_B/SZ_H/SZ_W), state enum, MASK table.
//   Sub-module lsu_align: combinational lane shift + sign/zero extension (load path).
// TESTING
//   lw 0x100, ack 2 cycles late, rdata 0xDEADBEEF -> one access be=1111, rsp 0xDEADBEEF.
//   lb 0x103, rdata 0x80000000 -> be=1000, rsp 0xFFFFFF80; lbu -> 0x00000080.
//   lh 0x103: rdata 0xAB000000 @0x100, 0x000000CD @0x104 -> two accesses be 1000/0001, rsp 0xFFFFCDAB; lhu -> 0x0000CDAB.
//   sw 0x102 wdata 0x11223344 -> @0x100 be=1100 wdata 0x33440000; @0x104 be=0011 wdata 0x00001122.
//   MAX_WAIT=4, no ack -> mem_req drops after 4 cycles, rsp_valid&rsp_err, rdata 0; size=11 -> err, no mem_req.
//   rst_n low during ACC1 -> mem_req 0 same cycle, no rsp_valid; new request then completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: size codes, FSM states,
// byte-mask table and small lane helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  // Right-aligned byte mask per size code, 4 bits per entry (entry 3 is illegal).
  localparam logic [15:0] MASK_TABLE = 16'h0F31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    return MASK_TABLE[{sz, 2'b00} +: 4];
  endfunction

  // Access straddles a word boundary when its last byte lands past lane 3.
  function automatic logic is_split(input logic [1:0] off, input logic [1:0] sz);
    logic [2:0] nbytes;
    case (sz)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      SZ_W:    nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    return ({1'b0, off} + nbytes) > 3'd4;
  endfunction

  // Widen an 8-lane byte enable into a 64-bit data mask.
  function automatic logic [63:0] be_expand(input logic [7:0] be);
    logic [63:0] m;
    m = 64'h0;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline-side and memory-side bundles of the load/store sequencer.
interface lsu_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  // Pipeline MEM stage issues requests.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
  // Sequencer accepts requests.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Sequencer drives the bus.
  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );
  // Data memory answers.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Load path: shift the two-word read window down to the request offset,
// then truncate to size and sign/zero-extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] win_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] sh_s;

  assign sh_s = 32'(win_i >> {off_i, 3'b000});

  // Truncate and extend the shifted data according to the access size.
  always_comb begin
    data_o = 32'h0;
    case (size_i)
      SZ_B:    data_o = unsigned_i ? {24'h0, sh_s[7:0]}  : {{24{sh_s[7]}}, sh_s[7:0]};
      SZ_H:    data_o = unsigned_i ? {16'h0, sh_s[15:0]} : {{16{sh_s[15]}}, sh_s[15:0]};
      SZ_W:    data_o = sh_s;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: takes one request from the MEM stage, performs one or
// two word-aligned bus accesses, and returns one response pulse.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_pipe_if.slave pipe,
  lsu_mem_if.master mem
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        we_q, uns_q, split_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] addr_q, wdata_q, lo_q;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        accept_s, cap_lo_s;
  logic [7:0]  be8_s;
  logic [63:0] wd64_s, win_s;
  logic [31:0] load_s;

  // Byte enables and write data laid out over the 8-byte window of two words.
  assign be8_s  = {4'b0000, size_mask(size_q)} << off_q;
  assign wd64_s = ({32'h0, wdata_q} << {off_q, 3'b000}) & be_expand(be8_s);

  // The word returned in the current cycle joins the one captured earlier.
  assign win_s = {(state_q == ST_ACC1) ? mem.mem_rdata : 32'h0,
                  (state_q == ST_ACC0) ? mem.mem_rdata : lo_q};

  lsu_align u_align (
    .win_i      (win_s),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_s)
  );

  // Next state, wait counter and response values for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    accept_s    = 1'b0;
    cap_lo_s    = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (pipe.req_valid) begin
          accept_s = 1'b1;
          wait_d   = 8'h0;
          if (pipe.req_size == SZ_X) begin
            state_d     = ST_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d = ST_ACC0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC0, ST_ACC1: begin
        if (mem.mem_ack) begin
          wait_d   = 8'h0;
          cap_lo_s = (state_q == ST_ACC0);
          if (state_q == ST_ACC0 && split_q) begin
            state_d = ST_ACC1;
          end else begin
            state_d     = ST_RESP;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = we_q ? 32'h0 : load_s;
          end
        end else if (wait_q == WAIT_LAST) begin
          // Hung access: abandon the bus and report an error.
          state_d     = ST_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decoded from the registered state and latched request.
  always_comb begin
    mem.mem_addr  = 32'h0;
    mem.mem_be    = 4'h0;
    mem.mem_wdata = 32'h0;
    case (state_q)
      ST_ACC0: begin
        mem.mem_addr  = addr_q;
        mem.mem_be    = be8_s[3:0];
        mem.mem_wdata = wd64_s[31:0];
      end
      ST_ACC1: begin
        mem.mem_addr  = addr_q + 32'd4;
        mem.mem_be    = be8_s[7:4];
        mem.mem_wdata = wd64_s[63:32];
      end
      default: begin
        mem.mem_addr  = 32'h0;
        mem.mem_be    = 4'h0;
        mem.mem_wdata = 32'h0;
      end
    endcase
  end

  assign mem.mem_req     = (state_q == ST_ACC0) || (state_q == ST_ACC1);
  assign mem.mem_we      = mem.mem_req & we_q;
  assign pipe.req_ready  = (state_q == ST_IDLE);
  assign pipe.busy       = (state_q != ST_IDLE);
  assign pipe.rsp_valid  = (state_q == ST_RESP);
  assign pipe.rsp_rdata  = rsp_rdata_q;
  assign pipe.rsp_err    = rsp_err_q;

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 8'h0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Latch the request on acceptance; addresses are kept word-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept_s) begin
      we_q    <= pipe.req_we;
      uns_q   <= pipe.req_unsigned;
      split_q <= is_split(pipe.req_addr[1:0], pipe.req_size);
      size_q  <= pipe.req_size;
      off_q   <= pipe.req_addr[1:0];
      addr_q  <= {pipe.req_addr[31:2], 2'b00};
      wdata_q <= pipe.req_wdata;
    end
  end

  // Low read word and response registers; responses hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q        <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (cap_lo_s) begin
        lo_q <= mem.mem_rdata;
      end
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, random requests
// against a byte-level reference model, and a reset-during-access sequence.
module tb_lsu_ctrl;

  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_pipe_if pipe ();
  lsu_mem_if  mem ();

  lsu_ctrl #(.MAX_WAIT(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pipe  (pipe),
    .mem   (mem)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] memw [logic [31:0]];

  int          obs_n;
  logic [31:0] obs_addr [4];
  logic [3:0]  obs_be [4];
  logic [31:0] obs_wd [4];
  logic        obs_we [4];
  int          obs_hold [4];
  logic [31:0] obs_rdata;
  logic        obs_err;
  int          obs_lat;

  typedef struct {
    logic we; logic [1:0] sz; logic uns; logic [31:0] addr; logic [31:0] wdata;
    int d0; int d1; logic [31:0] m0; logic [31:0] m1;
    int n; logic [31:0] a1; logic [3:0] be0; logic [3:0] be1;
    logic [31:0] wd0; logic [31:0] wd1; logic [31:0] rd; logic err;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdword(input logic [31:0] a);
    if (!memw.exists(a)) memw[a] = $urandom;
    return memw[a];
  endfunction

  // Issue one request and act as the memory; records what the DUT did.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int d0, input int d1);
    int dl [2];
    int hold;
    int di;
    bit done;
    dl[0] = d0; dl[1] = d1;
    obs_n = 0; hold = 0; done = 1'b0; obs_lat = -1;
    obs_rdata = 32'h0; obs_err = 1'b0;
    mem.mem_ack = 1'b0;
    chk("ready_before", 32'(pipe.req_ready), 32'd1);
    pipe.req_valid = 1'b1; pipe.req_we = we; pipe.req_size = sz;
    pipe.req_unsigned = uns; pipe.req_addr = addr; pipe.req_wdata = wd;
    @(negedge clk);
    pipe.req_valid = 1'b0;
    pipe.req_addr = $urandom; pipe.req_wdata = $urandom;
    pipe.req_we = 1'($urandom); pipe.req_size = 2'($urandom); pipe.req_unsigned = 1'($urandom);
    for (int c = 1; c <= 60 && !done; c++) begin
      if (pipe.rsp_valid) begin
        obs_lat = c; obs_rdata = pipe.rsp_rdata; obs_err = pipe.rsp_err;
        done = 1'b1; mem.mem_ack = 1'b0;
      end else begin
        if (mem.mem_req) begin
          if (hold == 0 && obs_n < 4) begin
            obs_addr[obs_n] = mem.mem_addr; obs_be[obs_n] = mem.mem_be;
            obs_wd[obs_n] = mem.mem_wdata; obs_we[obs_n] = mem.mem_we;
            obs_n++;
          end
          hold++;
          obs_hold[obs_n-1] = hold;
          di = (obs_n <= 2) ? dl[obs_n-1] : 0;
          if (hold - 1 == di) begin
            mem.mem_ack = 1'b1; mem.mem_rdata = rdword(mem.mem_addr); hold = 0;
          end else begin
            mem.mem_ack = 1'b0; mem.mem_rdata = $urandom;
          end
        end else begin
          mem.mem_ack = 1'b0; hold = 0;
        end
        @(negedge clk);
      end
    end
    chk("rsp_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("pulse_one", 32'(pipe.rsp_valid), 32'd0);
    chk("ready_after", 32'(pipe.req_ready), 32'd1);
    chk("rsp_hold", pipe.rsp_rdata, obs_rdata);
  endtask

  // Reference: reason byte by byte about which words/lanes a request touches.
  task automatic check_model(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int d0, input int d1);
    int dl [2];
    int nb, off, nacc, to, ndone, lat, lane;
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];
    logic [31:0] eaddr [2];
    logic [31:0] v, w;
    dl[0] = d0; dl[1] = d1;
    if (sz == 2'b11) begin
      chk("m_illegal_n", 32'(obs_n), 32'd0);
      chk("m_illegal_err", 32'(obs_err), 32'd1);
      chk("m_illegal_rd", obs_rdata, 32'h0);
      chk("m_illegal_lat", 32'(obs_lat), 32'd1);
      return;
    end
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = int'(addr[1:0]);
    nacc = (off + nb > 4) ? 2 : 1;
    for (int j = 0; j < 2; j++) begin
      ebe[j] = 4'h0; ewd[j] = 32'h0;
      eaddr[j] = {addr[31:2], 2'b00} + 32'(4 * j);
    end
    for (int k = 0; k < nb; k++) begin
      lane = off + k;
      ebe[lane/4][lane%4] = 1'b1;
      ewd[lane/4][8*(lane%4) +: 8] = wd[8*k +: 8];
    end
    to = -1;
    for (int j = 0; j < nacc; j++) if (to < 0 && dl[j] >= MW) to = j;
    ndone = (to < 0) ? nacc : to + 1;
    lat = 1;
    for (int j = 0; j < ndone; j++) lat += (j == to) ? MW : dl[j] + 1;
    chk("m_naccess", 32'(obs_n), 32'(ndone));
    chk("m_latency", 32'(obs_lat), 32'(lat));
    for (int j = 0; j < ndone && j < obs_n; j++) begin
      chk("m_addr", obs_addr[j], eaddr[j]);
      chk("m_be", 32'(obs_be[j]), 32'(ebe[j]));
      chk("m_we", 32'(obs_we[j]), 32'(we));
      chk("m_hold", 32'(obs_hold[j]), 32'((j == to) ? MW : dl[j] + 1));
      if (we) chk("m_wdata", obs_wd[j], ewd[j]);
    end
    if (to >= 0) begin
      chk("m_to_err", 32'(obs_err), 32'd1);
      chk("m_to_rd", obs_rdata, 32'h0);
    end else begin
      v = 32'h0;
      if (!we) begin
        for (int k = 0; k < nb; k++) begin
          lane = off + k;
          w = rdword(eaddr[lane/4]);
          v[8*k +: 8] = w[8*(lane%4) +: 8];
        end
        if (!uns && nb == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
        if (!uns && nb == 2 && v[15]) v[31:16] = 16'hFFFF;
      end
      chk("m_err", 32'(obs_err), 32'd0);
      chk("m_rdata", obs_rdata, v);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem.mem_ack = 1'($urandom); mem.mem_rdata = $urandom;
      chk("idle_no_rsp", 32'(pipe.rsp_valid), 32'd0);
      chk("idle_not_busy", 32'(pipe.busy), 32'd0);
      @(negedge clk);
    end
    mem.mem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] b;
    logic        r_we, r_uns;
    logic [1:0]  r_sz;
    logic [31:0] r_addr, r_wd;
    int          r_d0, r_d1;
    bit          found;

    pipe.req_valid = 1'b0; pipe.req_we = 1'b0; pipe.req_size = 2'b00;
    pipe.req_unsigned = 1'b0; pipe.req_addr = 32'h0; pipe.req_wdata = 32'h0;
    mem.mem_ack = 1'b0; mem.mem_rdata = 32'h0;

    vt[0] = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 2, 0, 32'hDEADBEEF, 32'h0,
              1, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[1] = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80000000, 32'h0,
              1, 32'h0, 4'h8, 4'h0, 32'h0, 32'h0, 32'hFFFFFF80, 1'b0};
    vt[2] = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1, 0, 32'h80000000, 32'h0,
              1, 32'h0, 4'h8, 4'h0, 32'h0, 32'h0, 32'h00000080, 1'b0};
    vt[3] = '{1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 1, 0, 32'hAB000000, 32'h000000CD,
              2, 32'h104, 4'h8, 4'h1, 32'h0, 32'h0, 32'hFFFFCDAB, 1'b0};
    vt[4] = '{1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 0, 2, 32'hAB000000, 32'h000000CD,
              2, 32'h104, 4'h8, 4'h1, 32'h0, 32'h0, 32'h0000CDAB, 1'b0};
    vt[5] = '{1'b1, 2'b10, 1'b0, 32'h102, 32'h11223344, 0, 1, 32'h0, 32'h0,
              2, 32'h104, 4'hC, 4'h3, 32'h33440000, 32'h00001122, 32'h0, 1'b0};
    vt[6] = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 9, 0, 32'h12345678, 32'h0,
              1, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vt[7] = '{1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 0, 32'h12345678, 32'h0,
              0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vt[8] = '{1'b1, 2'b00, 1'b0, 32'h001, 32'hAABBCCDD, 1, 0, 32'h0, 32'h0,
              1, 32'h0, 4'h2, 4'h0, 32'h0000DD00, 32'h0, 32'h0, 1'b0};
    vt[9] = '{1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 0, 0, 32'h7F000000, 32'h00000012,
              2, 32'h0, 4'h8, 4'h1, 32'h0, 32'h0, 32'h0000127F, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(pipe.req_ready), 32'd1);
    chk("rst_busy", 32'(pipe.busy), 32'd0);
    chk("rst_rsp_valid", 32'(pipe.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", pipe.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(pipe.rsp_err), 32'd0);
    chk("rst_mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem.mem_we), 32'd0);
    chk("rst_mem_addr", mem.mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem.mem_be), 32'd0);
    chk("rst_mem_wdata", mem.mem_wdata, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      b = {vt[i].addr[31:2], 2'b00};
      memw[b] = vt[i].m0;
      memw[b + 32'd4] = vt[i].m1;
      run_txn(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wdata, vt[i].d0, vt[i].d1);
      chk("v_naccess", 32'(obs_n), 32'(vt[i].n));
      chk("v_err", 32'(obs_err), 32'(vt[i].err));
      chk("v_rdata", obs_rdata, vt[i].rd);
      if (vt[i].n >= 1) begin
        chk("v_addr0", obs_addr[0], b);
        chk("v_be0", 32'(obs_be[0]), 32'(vt[i].be0));
        if (vt[i].we) chk("v_wd0", obs_wd[0], vt[i].wd0);
      end
      if (vt[i].n == 2) begin
        chk("v_addr1", obs_addr[1], vt[i].a1);
        chk("v_be1", 32'(obs_be[1]), 32'(vt[i].be1));
        if (vt[i].we) chk("v_wd1", obs_wd[1], vt[i].wd1);
      end
      check_model(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wdata, vt[i].d0, vt[i].d1);
      idle(1);
    end

    // Random requests against the reference model
    for (int i = 0; i < 250; i++) begin
      r_we  = 1'($urandom);
      r_sz  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_uns = 1'($urandom);
      r_addr = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3)))
                                          : {20'h0, 12'($urandom)};
      r_wd = $urandom;
      r_d0 = ($urandom_range(0, 9) == 0) ? MW + 1 : $urandom_range(0, 3);
      r_d1 = ($urandom_range(0, 9) == 0) ? MW + 1 : $urandom_range(0, 3);
      run_txn(r_we, r_sz, r_uns, r_addr, r_wd, r_d0, r_d1);
      check_model(r_we, r_sz, r_uns, r_addr, r_wd, r_d0, r_d1);
      idle($urandom_range(0, 2));
    end

    // Reset asserted while the second half of a split load is on the bus
    memw[32'h100] = 32'hAB000000; memw[32'h104] = 32'h000000CD;
    pipe.req_valid = 1'b1; pipe.req_we = 1'b0; pipe.req_size = 2'b01;
    pipe.req_unsigned = 1'b0; pipe.req_addr = 32'h103; pipe.req_wdata = 32'h0;
    @(negedge clk);
    pipe.req_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem.mem_req && mem.mem_addr == 32'h104) begin
        found = 1'b1; mem.mem_ack = 1'b0;
      end else begin
        mem.mem_ack = mem.mem_req; mem.mem_rdata = rdword(mem.mem_addr);
        @(negedge clk);
      end
    end
    chk("rst_seq_acc1_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_seq_mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst_seq_ready", 32'(pipe.req_ready), 32'd1);
    chk("rst_seq_rsp_valid", 32'(pipe.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_seq_no_rsp", 32'(pipe.rsp_valid), 32'd0);
      @(negedge clk);
    end
    run_txn(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1, 0);
    check_model(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
